// File: rtl/grid_io_cfg_tile.sv
// grid_io_cfg_tile
//
// Perimeter I/O tile with NUM_IO GPIO subtiles. Configuration is shifted
// serially through an internal chain on prog_clk. It is copied into the
// active shadow register only when a commit arrives after exactly CHAIN_LEN
// enabled shifts. The shadow bits of each subtile select pad output enable
// (bit 0) and data polarity (bit 1).
//
// Ports:
//   prog_clk            single clock, rising edge
//   pReset              asynchronous active-low reset
//   ccff_head           serial configuration data in
//   ccff_en             shift enable
//   ccff_commit         commit request
//   ccff_tail           serial configuration data out (last chain bit)
//   cfg_done            last commit accepted (registered level)
//   cfg_err             last commit rejected (registered level)
//   gfpga_pad_GPIO_PAD  bidirectional pads
//   io_outpad           fabric-to-pad data
//   io_inpad            pad-to-fabric data
module grid_io_cfg_tile #(
    parameter int NUM_IO   = 8,
    parameter int CFG_BITS = 2
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              ccff_commit,
    output logic              ccff_tail,
    output logic              cfg_done,
    output logic              cfg_err,
    inout  wire  [0:NUM_IO-1] gfpga_pad_GPIO_PAD,
    input  logic [0:NUM_IO-1] io_outpad,
    output logic [0:NUM_IO-1] io_inpad
);

    localparam int CHAIN_LEN = NUM_IO * CFG_BITS;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 ovf_q, ovf_d;
    logic [CHAIN_LEN-1:0] sr_q, sr_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 commit_act;

    logic [0:NUM_IO-1]    sub_oe;
    logic [0:NUM_IO-1]    sub_inv;

    // State, chain, shadow and status registers.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sr_q    <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sr_q    <= sr_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. A commit outside IDLE takes priority over a
    // simultaneous shift, which is then dropped so the chain stays put.
    // In IDLE the commit is meaningless and any shift proceeds normally.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        sr_d       = sr_q;
        sh_d       = sh_q;
        done_d     = done_q;
        err_d      = err_q;
        cnt_inc    = cnt_q + CNT_W'(1);
        commit_act = ccff_commit && (state_q != IDLE);

        if (commit_act) begin
            if ((state_q == FULL) && !ovf_q) begin
                sh_d   = sr_q;
                done_d = 1'b1;
                err_d  = 1'b0;
            end else begin
                done_d = 1'b0;
                err_d  = 1'b1;
            end
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (ccff_en) begin
            sr_d[0] = ccff_head;
            for (int i = 1; i < CHAIN_LEN; i++) begin
                sr_d[i] = sr_q[i-1];
            end
            case (state_q)
                IDLE, SHIFT: begin
                    // The first shift of a new load withdraws the old success flag.
                    if (state_q == IDLE) begin
                        done_d = 1'b0;
                    end
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_W'(CHAIN_LEN)) ? FULL : SHIFT;
                end
                FULL: begin
                    ovf_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Per-subtile controls from the shadow register. With a single config
    // bit per subtile there is no polarity bit, so the data is never inverted.
    for (genvar k = 0; k < NUM_IO; k++) begin : g_sub
        assign sub_oe[k] = sh_q[k*CFG_BITS];
        if (CFG_BITS > 1) begin : g_inv
            assign sub_inv[k] = sh_q[k*CFG_BITS+1];
        end else begin : g_noinv
            assign sub_inv[k] = 1'b0;
        end
        assign gfpga_pad_GPIO_PAD[k] = sub_oe[k] ? (io_outpad[k] ^ sub_inv[k]) : 1'bz;
        assign io_inpad[k]           = gfpga_pad_GPIO_PAD[k] ^ sub_inv[k];
    end

    assign ccff_tail = sr_q[CHAIN_LEN-1];
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_grid_io_cfg_tile.sv
// Testbench for grid_io_cfg_tile.
//
// A behavioural model tracks the chain contents, the committed shadow word
// and the number of enabled shifts since the current load began; a commit is
// accepted exactly when that count equals CHAIN_LEN. A compare process checks
// every output shortly after each rising edge, and directed steps add
// hand-computed literal expectations.
module tb_grid_io_cfg_tile;

    localparam int NUM_IO   = 8;
    localparam int CFG_BITS = 2;
    localparam int CL       = NUM_IO * CFG_BITS;

    logic              prog_clk = 1'b0;
    logic              pReset;
    logic              ccff_head;
    logic              ccff_en;
    logic              ccff_commit;
    logic              ccff_tail;
    logic              cfg_done;
    logic              cfg_err;
    wire  [0:NUM_IO-1] pad;
    logic [0:NUM_IO-1] io_outpad;
    logic [0:NUM_IO-1] io_inpad;

    logic [0:NUM_IO-1] tb_pad_val = '0;
    logic [0:NUM_IO-1] tb_drive;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, bit i of m_sr is chain position i.
    logic [CL-1:0] m_sr     = '0;
    logic [CL-1:0] m_sh     = '0;
    int            m_shifts = 0;
    logic          m_done   = 1'b0;
    logic          m_err    = 1'b0;

    grid_io_cfg_tile #(
        .NUM_IO   (NUM_IO),
        .CFG_BITS (CFG_BITS)
    ) dut (
        .prog_clk           (prog_clk),
        .pReset             (pReset),
        .ccff_head          (ccff_head),
        .ccff_en            (ccff_en),
        .ccff_commit        (ccff_commit),
        .ccff_tail          (ccff_tail),
        .cfg_done           (cfg_done),
        .cfg_err            (cfg_err),
        .gfpga_pad_GPIO_PAD (pad),
        .io_outpad          (io_outpad),
        .io_inpad           (io_inpad)
    );

    always #5 prog_clk = ~prog_clk;

    // The bench drives a pad only while the model says the tile is not driving it.
    always_comb begin
        for (int k = 0; k < NUM_IO; k++) begin
            tb_drive[k] = !m_sh[k*CFG_BITS];
        end
    end

    for (genvar k = 0; k < NUM_IO; k++) begin : g_pad
        assign pad[k] = tb_drive[k] ? tb_pad_val[k] : 1'bz;
    end

    // Behavioural model: count enabled shifts per load; commit accepted iff count == CL.
    always @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            m_sr     = '0;
            m_sh     = '0;
            m_shifts = 0;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else if (ccff_commit && m_shifts > 0) begin
            if (m_shifts == CL) begin
                m_sh   = m_sr;
                m_done = 1'b1;
                m_err  = 1'b0;
            end else begin
                m_done = 1'b0;
                m_err  = 1'b1;
            end
            m_shifts = 0;
        end else if (ccff_en) begin
            if (m_shifts == 0) m_done = 1'b0;
            m_sr = {m_sr[CL-2:0], ccff_head};
            m_shifts++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll();
        logic [0:NUM_IO-1] exp_pad;
        logic [0:NUM_IO-1] exp_in;
        logic oe, inv;
        for (int k = 0; k < NUM_IO; k++) begin
            oe  = m_sh[k*CFG_BITS];
            inv = m_sh[k*CFG_BITS+1];
            if (oe) begin
                exp_pad[k] = io_outpad[k] ^ inv;
                exp_in[k]  = io_outpad[k];
            end else begin
                exp_pad[k] = tb_pad_val[k];
                exp_in[k]  = tb_pad_val[k] ^ inv;
            end
        end
        checkOutput("model_ccff_tail", 32'(ccff_tail), 32'(m_sr[CL-1]));
        checkOutput("model_cfg_done", 32'(cfg_done), 32'(m_done));
        checkOutput("model_cfg_err", 32'(cfg_err), 32'(m_err));
        checkOutput("model_pads", 32'(pad), 32'(exp_pad));
        checkOutput("model_io_inpad", 32'(io_inpad), 32'(exp_in));
    endtask

    always @(posedge prog_clk) begin
        #1;
        checkAll();
    end

    task automatic applyStimulus(input logic head, input logic en, input logic commit);
        @(negedge prog_clk);
        ccff_head   = head;
        ccff_en     = en;
        ccff_commit = commit;
    endtask

    task automatic shiftWord(input logic [CL-1:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            applyStimulus(val[i % CL], 1'b1, 1'b0);
        end
    endtask

    task automatic commitAndSettle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        pReset      = 1'b0;
        ccff_head   = 1'b0;
        ccff_en     = 1'b0;
        ccff_commit = 1'b0;
        io_outpad   = '0;

        // Reset: all pads released, io_inpad follows the pad.
        repeat (2) @(negedge prog_clk);
        tb_pad_val[3] = 1'b1;
        #1;
        checkOutput("rst_io_inpad3", 32'(io_inpad[3]), 32'd1);
        checkOutput("rst_ccff_tail", 32'(ccff_tail), 32'd0);
        checkOutput("rst_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
        @(negedge prog_clk);
        pReset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Good load: subtile 0 drives (oe=1, inv=0), subtile 1 hi-Z with inv=1.
        io_outpad[0]  = 1'b1;
        tb_pad_val[1] = 1'b0;
        shiftWord(16'h0009, CL);
        commitAndSettle();
        checkOutput("good_cfg_done", 32'(cfg_done), 32'd1);
        checkOutput("good_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("good_pad0", 32'(pad[0]), 32'd1);
        checkOutput("good_io_inpad1", 32'(io_inpad[1]), 32'd1);

        // Short load: rejected, shadow kept.
        io_outpad = 8'b0110_1001;
        shiftWord(16'hFFFF, 10);
        commitAndSettle();
        checkOutput("short_cfg_err", 32'(cfg_err), 32'd1);
        checkOutput("short_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("short_pad0", 32'(pad[0]), 32'd0);

        // Overshift: rejected, then a correct load succeeds.
        shiftWord(16'hFFFF, CL + 1);
        commitAndSettle();
        checkOutput("ovf_cfg_err", 32'(cfg_err), 32'd1);
        io_outpad[1]  = 1'b1;
        tb_pad_val[0] = 1'b0;
        shiftWord(16'h0006, CL);
        commitAndSettle();
        checkOutput("reload_cfg_done", 32'(cfg_done), 32'd1);
        checkOutput("reload_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("reload_pad1", 32'(pad[1]), 32'd1);
        checkOutput("reload_io_inpad0", 32'(io_inpad[0]), 32'd1);

        // Chain pass-through with alternating data starting at 1.
        for (int i = 0; i < CL; i++) applyStimulus(1'((i % 2) == 0), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("chain_tail_16", 32'(ccff_tail), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("chain_tail_17", 32'(ccff_tail), 32'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("chain_tail_hold", 32'(ccff_tail), 32'd0);
        for (int i = CL + 1; i < 2 * CL; i++) applyStimulus(1'((i % 2) == 0), 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("chain_tail_32", 32'(ccff_tail), 32'd1);
        commitAndSettle();
        checkOutput("chain_cfg_err", 32'(cfg_err), 32'd1);

        // Simultaneous shift and commit on the 16th bit: commit rejected, shift dropped.
        io_outpad = 8'b1010_0101;
        shiftWord(16'h0009, CL);
        commitAndSettle();
        checkOutput("pre_sim_cfg_done", 32'(cfg_done), 32'd1);
        shiftWord(16'hFFFF, CL - 1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("sim_cfg_err", 32'(cfg_err), 32'd1);
        checkOutput("sim_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("sim_pad0", 32'(pad[0]), 32'd1);

        // Reset mid-load: chain cleared, pads released.
        shiftWord(16'hFFFF, 5);
        @(negedge prog_clk);
        ccff_en    = 1'b0;
        tb_pad_val = 8'hA5;
        pReset     = 1'b0;
        #1;
        checkOutput("midrst_ccff_tail", 32'(ccff_tail), 32'd0);
        checkOutput("midrst_cfg_err", 32'(cfg_err), 32'd0);
        checkOutput("midrst_io_inpad", 32'(io_inpad), 32'hA5);
        checkAll();
        @(negedge prog_clk);
        pReset = 1'b1;

        // Commit in IDLE is ignored; a fresh full load then succeeds.
        commitAndSettle();
        checkOutput("idle_commit_err", 32'(cfg_err), 32'd0);
        checkOutput("idle_commit_done", 32'(cfg_done), 32'd0);
        shiftWord(16'h0009, CL);
        commitAndSettle();
        checkOutput("fresh_cfg_done", 32'(cfg_done), 32'd1);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
